// File: rtl/noise_pkg.sv
// noise_pkg: shared state encoding, channel count, default seeds and round-robin search for noise_sched
package noise_pkg;
  localparam int NCH = 3;
  localparam logic [11:0] SEED0_DEF = 12'hACE;
  localparam logic [11:0] SEED1_DEF = 12'h5A3;
  localparam logic [11:0] SEED2_DEF = 12'h1F7;
  typedef enum logic [2:0] {S_IDLE, S_SEED0, S_SEED1, S_SEED2, S_RUN, S_STEP, S_CAPT} state_e;
  typedef struct packed {
    logic       found;
    logic [1:0] grant;
  } rr_t;
  function automatic rr_t rr_next(input logic [1:0] last, input logic [NCH-1:0] en);
    rr_t r;
    logic [1:0] c;
    r = '0;
    for (int i = 1; i <= NCH; i++) begin
      c = 2'((int'(last) + i) % NCH);
      if (!r.found && en[c]) begin
        r.found = 1'b1;
        r.grant = c;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/noise_sched_tick_gen.sv
// tick_gen: free-running prescaler, tick high on count DIV-1 (clk, rst, clr in; tick out)
module tick_gen #(
  parameter int DIV = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == TOP;
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/noise_sched.sv
// noise_sched: seeds three external LFSRs then steps them round-robin at the tick rate, muxing samples onto out
module noise_sched
  import noise_pkg::*;
#(
  parameter int             W     = 12,
  parameter int             DIV   = 500,
  parameter logic [W-1:0]   SEED0 = W'(SEED0_DEF),
  parameter logic [W-1:0]   SEED1 = W'(SEED1_DEF),
  parameter logic [W-1:0]   SEED2 = W'(SEED2_DEF)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  input  logic [NCH-1:0] ch_en,
  input  logic [W-1:0]   sample0,
  input  logic [W-1:0]   sample1,
  input  logic [W-1:0]   sample2,
  output logic [W-1:0]   seed,
  output logic [NCH-1:0] seed_load,
  output logic [NCH-1:0] step,
  output logic [W-1:0]   out,
  output logic [1:0]     ch_sel,
  output logic           out_valid,
  output logic           busy
);
  state_e state_q, state_d;
  logic [1:0] last_q, last_d, ch_sel_q, ch_sel_d;
  logic [W-1:0] seed_q, seed_d, out_q, out_d;
  logic [NCH-1:0] seed_load_q, seed_load_d, step_q, step_d;
  logic out_valid_q, out_valid_d, busy_q, busy_d;
  logic tick, cap;
  rr_t rr;
  tick_gen #(.DIV(DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state_q == S_SEED2),
    .tick(tick)
  );
  always_comb begin
    rr      = rr_next(last_q, ch_en);
    state_d = state_q;
    last_d  = last_q;
    if (stop && state_q != S_IDLE) state_d = S_IDLE;
    else
      case (state_q)
        S_IDLE:  state_d = (start && !stop) ? S_SEED0 : S_IDLE;
        S_SEED0: state_d = S_SEED1;
        S_SEED1: state_d = S_SEED2;
        S_SEED2: state_d = S_RUN;
        S_RUN:
          if (tick && rr.found) begin
            state_d = S_STEP;
            last_d  = rr.grant;
          end
        S_STEP:  state_d = S_CAPT;
        S_CAPT:  state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    seed_load_d = state_d == S_SEED0 ? 3'b001 : state_d == S_SEED1 ? 3'b010 :
                  state_d == S_SEED2 ? 3'b100 : 3'b000;
    seed_d      = state_d == S_SEED0 ? SEED0 : state_d == S_SEED1 ? SEED1 :
                  state_d == S_SEED2 ? SEED2 : '0;
    step_d      = state_d == S_STEP ? 3'b001 << last_d : 3'b000;
    cap         = state_q == S_CAPT && state_d == S_RUN;
    out_d       = !cap ? out_q : last_q == 2'd0 ? sample0 : last_q == 2'd1 ? sample1 : sample2;
    ch_sel_d    = cap ? last_q : ch_sel_q;
    out_valid_d = cap;
    busy_d      = state_d != S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 2'd2;
      seed_q      <= '0;
      seed_load_q <= '0;
      step_q      <= '0;
      out_q       <= '0;
      ch_sel_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      seed_q      <= seed_d;
      seed_load_q <= seed_load_d;
      step_q      <= step_d;
      out_q       <= out_d;
      ch_sel_q    <= ch_sel_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  assign seed      = seed_q;
  assign seed_load = seed_load_q;
  assign step      = step_q;
  assign out       = out_q;
  assign ch_sel    = ch_sel_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_noise_sched.sv
// tb_noise_sched: scoreboard bench with LFSR plant and round-robin reference model for noise_sched
module tb_noise_sched;
  localparam int DIV = 4;
  localparam logic [11:0] SD [3] = '{12'hACE, 12'h5A3, 12'h1F7};
  typedef struct {
    logic [1:0]  ch;
    logic [11:0] v;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [2:0] ch_en = 3'b000;
  logic [11:0] lf [3];
  logic [11:0] seed, out;
  logic [2:0] seed_load, step;
  logic [1:0] ch_sel;
  logic out_valid, busy;
  exp_t q[$];
  exp_t e_m;
  int total = 0, passed = 0, cyc = 0, epoch = 0, prev_cyc = -1, prev_ep = -1;
  int vcnt = 0, s1cnt = 0, m_last = 2;
  int m_cnt [3] = '{0, 0, 0};
  logic [11:0] last_v = '0;
  noise_sched #(.W(12), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .ch_en(ch_en),
    .sample0(lf[0]), .sample1(lf[1]), .sample2(lf[2]),
    .seed(seed), .seed_load(seed_load), .step(step), .out(out),
    .ch_sel(ch_sel), .out_valid(out_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (step[1]) s1cnt <= s1cnt + 1;
  always @(posedge clk)
    for (int c = 0; c < 3; c++)
      if (seed_load[c]) lf[c] <= seed;
      else if (step[c]) lf[c] <= {lf[c][10:0], lf[c][11] ^ lf[c][5] ^ lf[c][3] ^ lf[c][0]};
  function automatic logic [11:0] lfsr_n(input logic [11:0] s, input int n);
    logic [11:0] r;
    r = s;
    repeat (n) r = {r[10:0], r[11] ^ r[5] ^ r[3] ^ r[0]};
    return r;
  endfunction
  function automatic int rr(input int last, input logic [2:0] en);
    for (int k = 1; k <= 3; k++)
      if (en[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_seed"}, seed, 0);
    chk({tag, "_seed_load"}, seed_load, 0);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_out"}, out, 0);
    chk({tag, "_ch_sel"}, ch_sel, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  task automatic push(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      g = rr(m_last, ch_en);
      if (g < 0) return;
      m_last = g;
      m_cnt[g]++;
      last_v = lfsr_n(SD[g], m_cnt[g]);
      q.push_back('{2'(g), last_v});
    end
  endtask
  task automatic drain(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain", q.size(), 0);
    #1;
  endtask
  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("seed_load0", seed_load, 3'b001);
    chk("seed0", seed, 12'hACE);
    chk("busy_seed", busy, 1);
    @(negedge clk);
    chk("seed_load1", seed_load, 3'b010);
    chk("seed1", seed, 12'h5A3);
    @(negedge clk);
    chk("seed_load2", seed_load, 3'b100);
    chk("seed2", seed, 12'h1F7);
    @(negedge clk);
    chk("seed_load_off", seed_load, 0);
    chk("seed_off", seed, 0);
  endtask
  always @(negedge clk)
    if (!rst && out_valid) begin
      vcnt++;
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e_m = q.pop_front();
        chk("ch_sel", ch_sel, e_m.ch);
        chk("out", out, e_m.v);
      end
      if (prev_ep == epoch && prev_cyc >= 0) chk("valid_period", cyc - prev_cyc, DIV);
      prev_cyc = cyc;
      prev_ep  = epoch;
    end
  initial begin
    int k, v0, s1, pch;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    ch_en = 3'b111;
    do_start();
    push(6);
    drain(60);
    ch_en = 3'b101;
    s1 = s1cnt;
    push(4);
    drain(60);
    chk("ch1_never_stepped", s1cnt - s1, 0);
    ch_en = 3'b000;
    epoch++;
    k = 0;
    repeat (20) begin
      @(negedge clk);
      if (step != 0 || out_valid) k++;
    end
    chk("idle_en_quiet", k, 0);
    #1 ch_en = 3'b010;
    push(1);
    drain(60);
    for (int i = 0; i < 6; i++) begin
      ch_en = 3'($urandom_range(1, 7));
      push(int'($urandom_range(1, 5)));
      if (i == 0) begin
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("start_in_run_no_seed", seed_load, 0);
        chk("start_in_run_busy", busy, 1);
      end
      drain(60);
    end
    pch = m_last;
    ch_en = 3'b001;
    k = 0;
    while (step == 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("stop_step_seen", step, 3'b001);
    stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    m_cnt[0]++;
    m_last = 0;
    epoch++;
    chk("stop_busy", busy, 0);
    chk("stop_step", step, 0);
    chk("stop_out_valid", out_valid, 0);
    chk("stop_out_hold", out, last_v);
    chk("stop_ch_sel_hold", ch_sel, pch);
    v0 = vcnt;
    repeat (8) @(negedge clk);
    chk("stop_no_valid", vcnt - v0, 0);
    chk("stop_idle_busy", busy, 0);
    ch_en = 3'b111;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    chk("rst_pre_seed_load1", seed_load, 3'b010);
    #1 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk) rst = 1'b0;
    m_cnt = '{0, 0, 0};
    m_last = 2;
    epoch++;
    do_start();
    push(3);
    drain(60);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    repeat (10) @(negedge clk);
    chk("final_idle", busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
